// File: rtl/snn_dbg_pkg.sv
// snn_dbg_pkg: shared constants, frame-state enum and snapshot bit layout for the debug frame reader
//
// Snapshot register layout (LSB first):
//   [MEM_LSB +: MEM_W]  membrane potential debug vector
//   [L1_LSB  +: L1_W ]  layer-1 spikes
//   [L2_LSB  +: L2_W ]  layer-2 spikes
//   [OUT_LSB +: OUT_W]  output spikes
//   [PAD_LSB +: ...  ]  zero padding up to a whole number of bytes
// The offsets are shared with the host-side frame decoder.
package snn_dbg_pkg;
  localparam int MEM_W = 90;
  localparam int L1_W = 8;
  localparam int L2_W = 8;
  localparam int OUT_W = 2;
  localparam int SPK_W = L1_W + L2_W + OUT_W;
  localparam int PAY_BYTES = (MEM_W + SPK_W + 7) / 8;
  localparam int SNAP_W = PAY_BYTES * 8;
  localparam int FRAME_BYTES = 3 + PAY_BYTES;
  localparam int MEM_LSB = 0;
  localparam int L1_LSB = MEM_LSB + MEM_W;
  localparam int L2_LSB = L1_LSB + L1_W;
  localparam int OUT_LSB = L2_LSB + L2_W;
  localparam int PAD_LSB = OUT_LSB + OUT_W;
  localparam logic [7:0] HEADER = 8'hA5;
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEQ,
    DROP,
    PAY
  } frame_state_e;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/snn_dbg_byte_mux.sv
// snn_dbg_byte_mux: selects payload byte k of the snapshot register
//
// Ports:
//   snap_i  snapshot register (PAY_BYTES bytes, byte 0 in the LSBs)
//   idx_i   payload byte index, 0..PAY_BYTES-1
//   byte_o  selected byte; indices past the payload read as zero
module snn_dbg_byte_mux
  import snn_dbg_pkg::*;
(
  input  logic [SNAP_W-1:0] snap_i,
  input  logic [3:0]        idx_i,
  output logic [7:0]        byte_o
);
  logic [127:0] ext;
  assign ext = {{(128 - SNAP_W){1'b0}}, snap_i};
  assign byte_o = ext[{idx_i, 3'b000} +: 8];
endmodule

// File: rtl/snn_debug_frame_reader.sv
// snn_debug_frame_reader: snapshots network debug/spike state and streams it as a 17-byte frame
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   capture_en              enables snapshots and drop counting
//   net_data_ready          network output strobe, level-sampled every clk
//   membrane_potential_in   90-bit membrane debug vector
//   spikes_layer1_in/2_in   layer-1 / layer-2 spikes
//   spikes_out_in           final output spikes
//   out_data/out_valid      frame byte stream toward the pin mux
//   out_ready               downstream accept
//   busy                    frame in progress
//   drop_count              saturating count of samples missed while busy
//
// Frame: HEADER, SEQ, DROP, PAY0..PAY13 (snapshot LSB byte first).
module snn_debug_frame_reader
  import snn_dbg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             capture_en,
  input  logic             net_data_ready,
  input  logic [MEM_W-1:0] membrane_potential_in,
  input  logic [L1_W-1:0]  spikes_layer1_in,
  input  logic [L2_W-1:0]  spikes_layer2_in,
  input  logic [OUT_W-1:0] spikes_out_in,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [7:0]       drop_count
);
  frame_state_e state_q, state_d;
  logic [SNAP_W-1:0] snap_q, snap_d, snap_new;
  logic [7:0] seq_q, seq_d;
  logic [7:0] drop_byte_q, drop_byte_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] pay_byte;
  logic cap, start, xfer, last;

  snn_dbg_byte_mux u_mux (
    .snap_i (snap_q),
    .idx_i  (idx_q),
    .byte_o (pay_byte)
  );

  assign cap = capture_en & net_data_ready;
  assign start = (state_q == IDLE) & cap;
  assign xfer = out_valid & out_ready;
  assign last = (state_q == PAY) & xfer & (idx_q == 4'(PAY_BYTES - 1));

  assign out_valid = state_q != IDLE;
  assign busy = out_valid;
  assign drop_count = drop_cnt_q;
  assign out_data = (state_q == HDR)  ? HEADER :
                    (state_q == SEQ)  ? seq_q :
                    (state_q == DROP) ? drop_byte_q :
                    (state_q == PAY)  ? pay_byte : 8'h00;

  always_comb begin
    snap_new = '0;
    snap_new[MEM_LSB +: MEM_W] = membrane_potential_in;
    snap_new[L1_LSB +: L1_W] = spikes_layer1_in;
    snap_new[L2_LSB +: L2_W] = spikes_layer2_in;
    snap_new[OUT_LSB +: OUT_W] = spikes_out_in;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = cap ? HDR : IDLE;
      HDR:  state_d = xfer ? SEQ : HDR;
      SEQ:  state_d = xfer ? DROP : SEQ;
      DROP: state_d = xfer ? PAY : DROP;
      PAY:  state_d = last ? IDLE : PAY;
      default: state_d = IDLE;
    endcase
  end

  // A capture clears the live drop counter and takes priority over counting;
  // any other qualifying sample is a drop, including the final payload cycle.
  always_comb begin
    snap_d = start ? snap_new : snap_q;
    drop_byte_d = start ? drop_cnt_q : drop_byte_q;
    drop_cnt_d = start ? 8'h00 : cap ? sat_inc(drop_cnt_q) : drop_cnt_q;
    idx_d = start ? 4'd0 :
            last ? 4'd0 :
            ((state_q == PAY) & xfer) ? idx_q + 4'd1 : idx_q;
    seq_d = last ? seq_q + 8'd1 : seq_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      snap_q <= '0;
      seq_q <= '0;
      drop_byte_q <= '0;
      drop_cnt_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      snap_q <= snap_d;
      seq_q <= seq_d;
      drop_byte_q <= drop_byte_d;
      drop_cnt_q <= drop_cnt_d;
      idx_q <= idx_d;
    end
  end
endmodule
